cpu_seq_controller: RTL
=======================

CPU_SEQ_CONTROLLER -- requirements
Module: cpu_seq_controller

Interface
REQ-001 SHALL have parameter NUM_REGS, default 20, meaning bus register count and one-hot width (minimum 4).
REQ-002 SHALL have parameter INST_W, default 23, meaning instruction word width.
REQ-003 SHALL have parameter OP_W, default 3, meaning opcode width (minimum 3); IDX_W = $clog2(NUM_REGS) is derived, not a parameter.
REQ-004 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port: rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port: start  input  1  request to execute the instruction on inst.
REQ-007 SHALL have port: inst  input  INST_W  instruction word, sampled only in IDLE with start=1.
REQ-008 SHALL have port: zero  input  1  ALU zero flag, sampled in DECODE.
REQ-009 SHALL have ports: r_en_oh  output  NUM_REGS  register capture enables; tri_oh  output  NUM_REGS  bus driver selects.
REQ-010 SHALL have ports: alu_sub  output  1  ALU subtract (else add); branch, inc_pc, busy, done, halted  output  1 each.

Function
REQ-011 SHALL decode the latched word as: opcode = ir[INST_W-1 -: OP_W], rd = next IDX_W bits, rs = next IDX_W bits; remaining bits ignored.
REQ-012 SHALL use opcodes 0 NOP, 1 MOV, 2 ADD, 3 SUB, 4 JMP, 5 BZ, 7 HALT; 6 and any code >= 8 SHALL behave as NOP.
REQ-013 SHALL implement states IDLE, DECODE, EX1, EX2, EX3, DONE, HALT; outputs are a combinational function of state and latched ir.
REQ-014 IDLE: all outputs 0; start=1 latches inst into ir and moves to DECODE; start=0 stays.
REQ-015 DECODE: branch=1 for JMP, or for BZ with zero=1; inc_pc=1 otherwise; NOP/JMP/BZ go to DONE, MOV/ADD/SUB to EX1, HALT to HALT.
REQ-016 EX1: MOV drives tri_oh[rs] and r_en_oh[rd], then DONE; ADD/SUB drive tri_oh[rd] and r_en_oh[NUM_REGS-2] (ALU A), then EX2.
REQ-017 EX2: drives tri_oh[rs], r_en_oh[NUM_REGS-1] (ALU G), alu_sub=1 for SUB, then EX3.
REQ-018 EX3: drives tri_oh[NUM_REGS-1] and r_en_oh[rd], then DONE.
REQ-019 DONE: done=1 for exactly one cycle, then IDLE; the same start may be accepted on the next cycle.
REQ-020 busy SHALL be 1 in DECODE, EX1, EX2, EX3 and DONE; 0 in IDLE and HALT.
REQ-021 HALT: halted=1, all other outputs 0, held until reset; start ignored.
REQ-022 At most one bit of tri_oh and at most one bit of r_en_oh SHALL be set in any cycle.
REQ-023 An rd or rs index >= NUM_REGS SHALL produce an all-zero vector for that one-hot output; sequencing unchanged.
REQ-024 start while busy=1 SHALL be ignored and ir SHALL NOT change.
REQ-025 Latency from start sampled: NOP/JMP/BZ done at cycle 2; MOV at cycle 3; ADD/SUB at cycle 5.

Reset
REQ-026 rst=0 at a rising edge SHALL force IDLE and clear ir, from any state including mid-instruction and HALT.
REQ-027 During and after reset all outputs SHALL be 0 until a new start is accepted.

Configuration
REQ-028 With CTRL_BRANCH_EN defined, JMP and BZ SHALL behave per REQ-015.
REQ-029 Without CTRL_BRANCH_EN, opcodes 4 and 5 SHALL behave as NOP (branch constant 0, inc_pc=1 in DECODE), and zero SHALL be unused.

Structure
REQ-030 Package ctrl_pkg SHALL hold the state enum and the opcode constants.
REQ-031 One sub-module, ctrl_onehot_dec (parameterised index width and output width, with out-of-range giving zero), SHALL be instantiated twice, once for r_en_oh and once for tri_oh.

Verification
REQ-032 Reset mid-ADD (in EX2), rst=0 for 1 cycle -> IDLE next cycle, all outputs 0, busy=0.
REQ-033 Defaults, MOV rd=3 rs=7 -> EX1 has tri_oh=1<<7 and r_en_oh=1<<3; done at cycle 3.
REQ-034 SUB rd=2 rs=5 -> EX1 has tri_oh bit 2 and r_en bit 18; EX2 has tri bit 5, r_en bit 19, alu_sub=1; EX3 has tri bit 19, r_en bit 2; done at cycle 5.
REQ-035 BZ with zero=1 -> branch=1 and inc_pc=0 in DECODE; with zero=0 -> branch=0 and inc_pc=1; without CTRL_BRANCH_EN -> branch=0 in both cases.
REQ-036 MOV rd=25 with defaults -> r_en_oh=0 in EX1; start held high during busy -> ir unchanged and no second instruction until done.
REQ-037 HALT -> halted=1 persists for 10 cycles with start=1; rst=0 -> IDLE, halted=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types for the CPU sequence controller: FSM states, opcode encodings
// and the opcode-classification helper.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EX1,
        S_EX2,
        S_EX3,
        S_DONE,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_MOV  = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_JMP  = 3'd4,
        OP_BZ   = 3'd5,
        OP_RSV  = 3'd6,
        OP_HALT = 3'd7
    } opcode_e;

    // Reserved code 6 and anything beyond the 3-bit range collapse to NOP.
    function automatic opcode_e op_classify(input logic [2:0] low, input logic in_range);
        opcode_e op;
        op = opcode_e'(low);
        if (!in_range || op == OP_RSV)
            op = OP_NOP;
        return op;
    endfunction

endpackage

// File: rtl/ctrl_onehot_dec.sv
// Index-to-one-hot decoder with enable; an index at or above OUT_W yields all zeros.
module ctrl_onehot_dec #(
    parameter int unsigned IDX_W = 5,
    parameter int unsigned OUT_W = 20
) (
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    output logic [OUT_W-1:0] oh
);

    always_comb begin
        oh = '0;
        for (int unsigned i = 0; i < OUT_W; i++) begin
            if (en && idx == IDX_W'(i))
                oh[i] = 1'b1;
        end
    end

endmodule

// File: rtl/cpu_seq_controller.sv
// Multi-cycle register-transfer sequencer for a bus-based CPU datapath.
// Define CTRL_BRANCH_EN to enable JMP/BZ; otherwise they execute as NOP.
module cpu_seq_controller
    import ctrl_pkg::*;
#(
    parameter int unsigned NUM_REGS = 20,
    parameter int unsigned INST_W   = 23,
    parameter int unsigned OP_W     = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [INST_W-1:0]   inst,
    input  logic                zero,
    output logic [NUM_REGS-1:0] r_en_oh,
    output logic [NUM_REGS-1:0] tri_oh,
    output logic                alu_sub,
    output logic                branch,
    output logic                inc_pc,
    output logic                busy,
    output logic                done,
    output logic                halted
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    state_e            state;
    logic [INST_W-1:0] ir;
    logic [OP_W-1:0]   opc;
    logic [IDX_W-1:0]  rd, rs;
    opcode_e           op;
    logic              take_branch;
    logic              ren_en, tri_en;
    logic [IDX_W-1:0]  ren_idx, tri_idx;

    assign opc = ir[INST_W-1 -: OP_W];
    assign rd  = ir[INST_W-1-OP_W -: IDX_W];
    assign rs  = ir[INST_W-1-OP_W-IDX_W -: IDX_W];
    assign op  = op_classify(opc[2:0], 32'(opc) < 32'd8);

`ifdef CTRL_BRANCH_EN
    assign take_branch = (op == OP_JMP) || (op == OP_BZ && zero);
`else
    assign take_branch = 1'b0;
`endif

    // Trailing instruction bits are don't-care; zero is unused without branches.
    logic unused_bits;
    assign unused_bits = ^{zero, ir};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            ir    <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    ir    <= inst;
                    state <= S_DECODE;
                end
                S_DECODE: case (op)
                    OP_MOV, OP_ADD, OP_SUB: state <= S_EX1;
                    OP_HALT:                state <= S_HALT;
                    default:                state <= S_DONE;
                endcase
                S_EX1:   state <= (op == OP_MOV) ? S_DONE : S_EX2;
                S_EX2:   state <= S_EX3;
                S_EX3:   state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ren_en  = 1'b0;
        tri_en  = 1'b0;
        ren_idx = '0;
        tri_idx = '0;
        alu_sub = 1'b0;
        branch  = 1'b0;
        inc_pc  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        halted  = 1'b0;
        case (state)
            S_DECODE: begin
                busy   = 1'b1;
                branch = take_branch;
                inc_pc = !take_branch;
            end
            S_EX1: begin
                busy   = 1'b1;
                ren_en = 1'b1;
                tri_en = 1'b1;
                if (op == OP_MOV) begin
                    tri_idx = rs;
                    ren_idx = rd;
                end else begin
                    tri_idx = rd;
                    ren_idx = IDX_W'(NUM_REGS - 2);
                end
            end
            S_EX2: begin
                busy    = 1'b1;
                ren_en  = 1'b1;
                tri_en  = 1'b1;
                tri_idx = rs;
                ren_idx = IDX_W'(NUM_REGS - 1);
                alu_sub = (op == OP_SUB);
            end
            S_EX3: begin
                busy    = 1'b1;
                ren_en  = 1'b1;
                tri_en  = 1'b1;
                tri_idx = IDX_W'(NUM_REGS - 1);
                ren_idx = rd;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    ctrl_onehot_dec #(.IDX_W(IDX_W), .OUT_W(NUM_REGS)) u_ren_dec (
        .en  (ren_en),
        .idx (ren_idx),
        .oh  (r_en_oh)
    );

    ctrl_onehot_dec #(.IDX_W(IDX_W), .OUT_W(NUM_REGS)) u_tri_dec (
        .en  (tri_en),
        .idx (tri_idx),
        .oh  (tri_oh)
    );

endmodule
